// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and types for the memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int MEM_RD_LAT = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rtl/mem_arbiter_rr_arbiter.sv - round-robin arbiter with combinational grant and registered pointer
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  int              w_pos;

  // Scan ptr, ptr+1, ... with wrap; the first requester found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_cand  = '0;
    w_pos   = 0;
    for (int o = 0; o < N; o++) begin
      w_pos = int'(r_ptr) + o;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = ID_W'(w_pos);
      if (!any && req[w_cand]) begin
        gnt[w_cand] = 1'b1;
        gnt_idx     = w_cand;
        any         = 1'b1;
      end
    end
  end

  // Move the pointer just past the winner so it has lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (any) begin
      r_ptr <= (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one read and one write memory port among N_REQ requesters (option: MEM_ARB_STATS_EN)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ADDR_W-1:0]       mem_raddr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_wen,
  output logic [ADDR_W-1:0]       mem_waddr,
  output logic [DATA_W-1:0]       mem_wdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_rd,
  output logic [31:0]             stat_wr,
  output logic [31:0]             stat_stall
`endif
);

  logic [N_REQ-1:0] w_rd_req;
  logic [N_REQ-1:0] w_wr_req;
  logic [N_REQ-1:0] w_rd_gnt;
  logic [N_REQ-1:0] w_wr_gnt;
  logic [ID_W-1:0]  w_rd_idx;
  logic [ID_W-1:0]  w_wr_idx;
  logic             w_rd_any;
  logic             w_wr_any;

  logic             r_s1_v;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_s2_v;
  logic [ID_W-1:0]  r_s2_id;

  assign w_rd_req = req_valid & ~req_we;
  assign w_wr_req = req_valid & req_we;

  rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_rd_req),
    .gnt     (w_rd_gnt),
    .gnt_idx (w_rd_idx),
    .any     (w_rd_any)
  );

  rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_wr_req),
    .gnt     (w_wr_gnt),
    .gnt_idx (w_wr_idx),
    .any     (w_wr_any)
  );

  assign req_gnt   = w_rd_gnt | w_wr_gnt;
  assign mem_raddr = w_rd_any ? req_addr[w_rd_idx*ADDR_W +: ADDR_W]  : '0;
  assign mem_wen   = w_wr_any;
  assign mem_waddr = w_wr_any ? req_addr[w_wr_idx*ADDR_W +: ADDR_W]  : '0;
  assign mem_wdata = w_wr_any ? req_wdata[w_wr_idx*DATA_W +: DATA_W] : '0;

  // Carry the read winner's id alongside the memory's two-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_s1_id <= '0;
      r_s2_v  <= 1'b0;
      r_s2_id <= '0;
    end else begin
      r_s1_v  <= w_rd_any;
      r_s1_id <= w_rd_idx;
      r_s2_v  <= r_s1_v;
      r_s2_id <= r_s1_id;
    end
  end

  assign rsp_valid = r_s2_v ? (N_REQ'(1) << r_s2_id) : '0;
  assign rsp_data  = r_s2_v ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = |(req_valid & ~req_gnt);

  // Saturating counts of read grants, write grants and cycles with a waiting request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_rd    <= '0;
      r_stat_wr    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_rd_any && (r_stat_rd != '1))    r_stat_rd    <= r_stat_rd + 32'd1;
      if (w_wr_any && (r_stat_wr != '1))    r_stat_wr    <= r_stat_wr + 32'd1;
      if (w_stall && (r_stat_stall != '1))  r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_rd    = r_stat_rd;
  assign stat_wr    = r_stat_wr;
  assign stat_stall = r_stat_stall;
`endif

endmodule
